// File: rtl/jk_sched_pkg.sv
// jk_sched_pkg
// Shared types and helpers for the JK bank scheduler.
//   jk_op_e        : command opcode (hold / clear / set / toggle)
//   sched_state_e  : scheduler FSM states
//   op_to_jk()     : maps an opcode to the {j,k} pair driven on selected bits
package jk_sched_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } sched_state_e;

  // Returns {j,k} for one bit cell under the given opcode.
  function automatic logic [1:0] op_to_jk(jk_op_e op);
    logic [1:0] jk;
    case (op)
      JK_HOLD: jk = 2'b00;
      JK_CLR:  jk = 2'b01;
      JK_SET:  jk = 2'b10;
      JK_TGL:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_bank.sv
// jk_bank
// A bank of N independent JK flip-flop bit cells.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, clears every cell
//   j, k    : per-bit JK inputs
//   q, qbar : per-bit state and its complement
module jk_bank #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] j,
  input  logic [N-1:0] k,
  output logic [N-1:0] q,
  output logic [N-1:0] qbar
);

  // Classic JK behaviour for each cell: 00 keep, 01 reset, 10 set, 11 invert.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        case ({j[i], k[i]})
          2'b00:   q[i] <= q[i];
          2'b01:   q[i] <= 1'b0;
          2'b10:   q[i] <= 1'b1;
          default: q[i] <= ~q[i];
        endcase
      end
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_bank_sched.sv
// jk_bank_sched
// Two-requester round-robin scheduler that owns a bank of N JK bit cells.
// A command (op, mask, rep) is accepted from one requester, then applied
// to the bank for rep+1 consecutive cycles.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   reqX_valid/op/mask/rep       : command from requester X (X = 0, 1)
//   reqX_ready                   : requester X's command is taken this cycle
//   q, qbar                      : bank state and complement
//   busy                         : a command is being applied
//   gnt                          : requester owning the current/last command
//   done                         : one-cycle pulse after the final application
module jk_bank_sched
  import jk_sched_pkg::*;
#(
  parameter int N     = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [N-1:0]     req0_mask,
  input  logic [REP_W-1:0] req0_rep,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [N-1:0]     req1_mask,
  input  logic [REP_W-1:0] req1_rep,
  output logic             req1_ready,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qbar,
  output logic             busy,
  output logic             gnt,
  output logic             done
);

  sched_state_e     state, state_next;
  logic             ptr;
  logic             winner;
  logic             accept;
  logic             last_apply;
  jk_op_e           cmd_op;
  logic [N-1:0]     cmd_mask;
  logic [REP_W-1:0] remaining;
  logic [1:0]       cmd_jk;
  logic [N-1:0]     bank_j, bank_k;

  // State register for the IDLE/APPLY sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode. In IDLE the winner is the pointer's
  // choice only under contention; a lone requester always wins. Ready is
  // purely combinational so the requester sees it in the accept cycle.
  always_comb begin
    state_next = state;
    winner     = 1'b0;
    accept     = 1'b0;
    last_apply = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          winner     = (req0_valid && req1_valid) ? ptr : req1_valid;
          accept     = 1'b1;
          req0_ready = ~winner;
          req1_ready = winner;
          state_next = APPLY;
        end
      end
      APPLY: begin
        if (remaining == '0) begin
          last_apply = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture, round-robin pointer and repeat counter. The pointer
  // flips to the loser after every accept so contention alternates. The
  // done pulse is registered off the last application, which lands it in
  // the cycle right after the final bank update; reset suppresses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      cmd_op    <= JK_HOLD;
      cmd_mask  <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= last_apply;
      if (accept) begin
        cmd_op    <= jk_op_e'(winner ? req1_op : req0_op);
        cmd_mask  <= winner ? req1_mask : req0_mask;
        remaining <= winner ? req1_rep : req0_rep;
        gnt       <= winner;
        ptr       <= ~winner;
      end else if (state == APPLY && remaining != '0) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Bank drive: only while applying, and only on masked bits; everything
  // else sees J=K=0 and holds.
  always_comb begin
    cmd_jk = op_to_jk(cmd_op);
    bank_j = '0;
    bank_k = '0;
    if (state == APPLY) begin
      bank_j = cmd_mask & {N{cmd_jk[1]}};
      bank_k = cmd_mask & {N{cmd_jk[0]}};
    end
  end

  assign busy = (state == APPLY);

  jk_bank #(.N(N)) u_bank (
    .clk  (clk),
    .rst  (rst),
    .j    (bank_j),
    .k    (bank_k),
    .q    (q),
    .qbar (qbar)
  );

endmodule

// File: tb/tb_jk_bank_sched.sv
// tb_jk_bank_sched
// Self-checking bench for jk_bank_sched. A transaction-level model tracks
// the bank value, who owns the bank and how many applications are left.
module tb_jk_bank_sched;

  localparam int N     = 8;
  localparam int REP_W = 4;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [1:0]       req0_op, req1_op;
  logic [N-1:0]     req0_mask, req1_mask;
  logic [REP_W-1:0] req0_rep, req1_rep;
  logic             req0_ready, req1_ready;
  logic [N-1:0]     q, qbar;
  logic             busy, gnt, done;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state
  logic [N-1:0] mQ;
  logic         mPtr;
  logic         mGnt;
  logic         mBusy;
  logic         mDone;
  int           mLeft;
  logic [1:0]   mOp;
  logic [N-1:0] mMask;

  jk_bank_sched #(.N(N), .REP_W(REP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_mask  (req0_mask),
    .req0_rep   (req0_rep),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_mask  (req1_mask),
    .req1_rep   (req1_rep),
    .req1_ready (req1_ready),
    .q          (q),
    .qbar       (qbar),
    .busy       (busy),
    .gnt        (gnt),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank effect of one application, as plain bitwise arithmetic.
  function automatic logic [N-1:0] applyOp(logic [N-1:0] cur, logic [1:0] op, logic [N-1:0] m);
    case (op)
      2'd1:    return cur & ~m;
      2'd2:    return cur | m;
      2'd3:    return cur ^ m;
      default: return cur;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Drives one cycle of inputs (called just after a falling edge), checks
  // every output against the model, then advances the model over the
  // rising edge and returns at the next falling edge.
  task automatic applyStimulus(
    input logic v0, input logic [1:0] op0, input logic [N-1:0] m0, input logic [REP_W-1:0] r0,
    input logic v1, input logic [1:0] op1, input logic [N-1:0] m1, input logic [REP_W-1:0] r1,
    input logic r);
    logic anyV, expW, expR0, expR1;
    req0_valid = v0; req0_op = op0; req0_mask = m0; req0_rep = r0;
    req1_valid = v1; req1_op = op1; req1_mask = m1; req1_rep = r1;
    rst = r;
    anyV  = v0 | v1;
    expW  = (v0 && v1) ? mPtr : v1;
    expR0 = !mBusy && anyV && !expW;
    expR1 = !mBusy && anyV && expW;
    #1;
    checkOutput("ready0", {31'b0, req0_ready}, {31'b0, expR0});
    checkOutput("ready1", {31'b0, req1_ready}, {31'b0, expR1});
    checkOutput("q",      {24'b0, q},          {24'b0, mQ});
    checkOutput("qbar",   {24'b0, qbar},       {24'b0, ~mQ});
    checkOutput("busy",   {31'b0, busy},       {31'b0, mBusy});
    checkOutput("done",   {31'b0, done},       {31'b0, mDone});
    checkOutput("gnt",    {31'b0, gnt},        {31'b0, mGnt});
    @(posedge clk);
    if (r) begin
      mQ = '0; mPtr = 1'b0; mGnt = 1'b0; mBusy = 1'b0; mDone = 1'b0; mLeft = 0;
    end else begin
      mDone = 1'b0;
      if (mBusy) begin
        mQ = applyOp(mQ, mOp, mMask);
        mLeft--;
        if (mLeft == 0) begin
          mBusy = 1'b0;
          mDone = 1'b1;
        end
      end else if (anyV) begin
        mOp   = expW ? op1 : op0;
        mMask = expW ? m1 : m0;
        mLeft = (expW ? int'(r1) : int'(r0)) + 1;
        mGnt  = expW;
        mPtr  = ~expW;
        mBusy = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resetCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Directed scenarios followed by a randomized soak.
  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_op = 0; req0_mask = 0; req0_rep = 0;
    req1_valid = 0; req1_op = 0; req1_mask = 0; req1_rep = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mQ = '0; mPtr = 1'b0; mGnt = 1'b0; mBusy = 1'b0; mDone = 1'b0; mLeft = 0;
    mOp = 2'd0; mMask = '0;
    $display("[TB] reset and idle");
    resetCycle();
    idleCycles(2);
    checkOutput("rst_q",    {24'b0, q},    32'h00);
    checkOutput("rst_qbar", {24'b0, qbar}, 32'hFF);

    $display("[TB] single set");
    applyStimulus(1, 2'b10, 8'hA5, 0, 0, 0, 0, 0, 0);
    idleCycles(3);
    checkOutput("set_q", {24'b0, q}, 32'hA5);

    $display("[TB] repeated toggle");
    resetCycle();
    applyStimulus(0, 0, 0, 0, 1, 2'b11, 8'h0F, 2, 0);
    idleCycles(5);
    checkOutput("tgl_q",   {24'b0, q}, 32'h0F);
    checkOutput("tgl_gnt", {31'b0, gnt}, 32'h1);

    $display("[TB] contention");
    resetCycle();
    for (int i = 0; i < 8; i++) applyStimulus(1, 2'b10, 8'h01, 0, 1, 2'b10, 8'h02, 0, 0);
    idleCycles(2);
    checkOutput("cont_q", {24'b0, q}, 32'h03);

    $display("[TB] masked clear and hold");
    applyStimulus(1, 2'b10, 8'hFF, 0, 0, 0, 0, 0, 0);
    idleCycles(2);
    applyStimulus(1, 2'b01, 8'hF0, 0, 0, 0, 0, 0, 0);
    idleCycles(2);
    checkOutput("clr_q", {24'b0, q}, 32'h0F);
    applyStimulus(1, 2'b00, 8'hFF, 3, 0, 0, 0, 0, 0);
    idleCycles(6);
    checkOutput("hold_q", {24'b0, q}, 32'h0F);

    $display("[TB] reset mid-operation");
    applyStimulus(1, 2'b11, 8'h3C, 7, 0, 0, 0, 0, 0);
    idleCycles(2);
    resetCycle();
    idleCycles(2);
    checkOutput("midrst_q", {24'b0, q}, 32'h00);
    applyStimulus(1, 2'b10, 8'h01, 0, 1, 2'b10, 8'h02, 0, 0);
    checkOutput("midrst_gnt", {31'b0, gnt}, 32'h0);
    idleCycles(2);

    $display("[TB] random soak");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 1), 2'($urandom), 8'($urandom), 4'($urandom_range(0, 5)),
                    $urandom_range(0, 1), 2'($urandom), 8'($urandom), 4'($urandom_range(0, 5)),
                    ($urandom_range(0, 59) == 0));
    end
    idleCycles(8);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
